// File: rtl/dram_perf_seq.sv
// dram_perf_seq: runs a DRAM perf engine through N write/read passes and accumulates counts, latency and errors.
// Latency: enable rises 2 cycles after start and drops 1 cycle after done; at most 4 cycles of overhead per pass.
// Backpressure: none upstream; each phase waits on the engine done level, bounded by cfg_timeout when non-zero.
module dram_perf_seq #(
  parameter int ITER_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [31:0]       cfg_start_addr,
  input  logic [31:0]       cfg_addr_stride,
  input  logic [31:0]       cfg_burst_len,
  input  logic [31:0]       cfg_seed,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic [31:0]       cfg_timeout,
  output logic              mc_wr_enable,
  output logic              mc_rd_enable,
  output logic [31:0]       mc_start_addr,
  output logic [31:0]       mc_burst_len,
  output logic [31:0]       mc_write_val,
  input  logic              mc_wr_done,
  input  logic              mc_rd_done,
  input  logic [31:0]       mc_rhash,
  input  logic [31:0]       mc_rd_clk_count,
  input  logic [31:0]       mc_wr_clk_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_idx,
  output logic [ACC_W-1:0]  rd_cycles_total,
  output logic [ACC_W-1:0]  wr_cycles_total,
  output logic [31:0]       rd_lat_min,
  output logic [31:0]       rd_lat_max,
  output logic [ITER_W-1:0] mismatch_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_REQ = 3'd1;
  localparam logic [2:0] S_WR_REL = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_REL = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [ITER_W-1:0] iters_q;
  logic [31:0]       stride_q;
  logic [31:0]       burst_q;
  logic [31:0]       timeout_q;
  logic [31:0]       addr_q;
  logic [31:0]       val_q;
  logic [31:0]       phase_cnt;

  logic start_go;
  logic in_phase;
  logic phase_ok;
  logic tmo_hit;
  logic wr_fire;
  logic rd_fire;

  // Saturating add of a 32-bit engine count into a wide accumulator.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [31:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, {(ACC_W-32){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign busy     = !(state == S_IDLE || state == S_DONE || state == S_ERR);
  assign start_go = start && !busy;
  assign wr_fire  = (state == S_WR_REQ) && mc_wr_done;
  assign rd_fire  = (state == S_RD_REQ) && mc_rd_done;

  // Decode which states are engine handshake phases and whether the awaited done level is present.
  always_comb begin
    in_phase = 1'b0;
    phase_ok = 1'b0;
    case (state)
      S_WR_REQ: begin in_phase = 1'b1; phase_ok = mc_wr_done;  end
      S_WR_REL: begin in_phase = 1'b1; phase_ok = !mc_wr_done; end
      S_RD_REQ: begin in_phase = 1'b1; phase_ok = mc_rd_done;  end
      S_RD_REL: begin in_phase = 1'b1; phase_ok = !mc_rd_done; end
      default:  begin in_phase = 1'b0; phase_ok = 1'b0;        end
    endcase
  end

  // Phase fires the abort on its cfg_timeout-th waiting cycle; completion wins over a same-cycle timeout.
  assign tmo_hit = in_phase && !phase_ok && (timeout_q != 32'd0) &&
                   (phase_cnt >= timeout_q - 32'd1);

  // Phase cycle counter, zero on entry to every handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= 32'd0;
    end else if (in_phase && !phase_ok) begin
      phase_cnt <= phase_cnt + 32'd1;
    end else begin
      phase_cnt <= 32'd0;
    end
  end

  // Pass sequencer: config latch, engine enables/arguments, pass advance and terminal flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 2'd0;
      iters_q       <= '0;
      stride_q      <= 32'd0;
      burst_q       <= 32'd0;
      timeout_q     <= 32'd0;
      addr_q        <= 32'd0;
      val_q         <= 32'd0;
      iter_idx      <= '0;
      mc_wr_enable  <= 1'b0;
      mc_rd_enable  <= 1'b0;
      mc_start_addr <= 32'd0;
      mc_burst_len  <= 32'd0;
      mc_write_val  <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            mode_q    <= cfg_mode;
            iters_q   <= cfg_iters;
            stride_q  <= cfg_addr_stride;
            burst_q   <= cfg_burst_len;
            timeout_q <= cfg_timeout;
            addr_q    <= cfg_start_addr;
            val_q     <= cfg_seed;
            iter_idx  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          // Arguments change only here so they are stable across both phases of a pass.
          mc_start_addr <= addr_q;
          mc_burst_len  <= burst_q;
          mc_write_val  <= val_q;
          if (iter_idx == iters_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (mode_q == 2'd1) begin
            mc_rd_enable <= 1'b1;
            state        <= S_RD_REQ;
          end else begin
            mc_wr_enable <= 1'b1;
            state        <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (mc_wr_done) begin
            mc_wr_enable <= 1'b0;
            state        <= S_WR_REL;
          end else if (tmo_hit) begin
            mc_wr_enable <= 1'b0;
            mc_rd_enable <= 1'b0;
            err          <= 1'b1;
            state        <= S_ERR;
          end
        end
        S_WR_REL: begin
          if (!mc_wr_done) begin
            // Modes 2 and 3 follow the write with a read of the same lines.
            if (mode_q[1]) begin
              mc_rd_enable <= 1'b1;
              state        <= S_RD_REQ;
            end else begin
              iter_idx <= iter_idx + ITER_W'(1);
              addr_q   <= addr_q + stride_q;
              val_q    <= val_q + 32'd1;
              state    <= S_NEXT;
            end
          end else if (tmo_hit) begin
            mc_wr_enable <= 1'b0;
            mc_rd_enable <= 1'b0;
            err          <= 1'b1;
            state        <= S_ERR;
          end
        end
        S_RD_REQ: begin
          if (mc_rd_done) begin
            mc_rd_enable <= 1'b0;
            state        <= S_RD_REL;
          end else if (tmo_hit) begin
            mc_wr_enable <= 1'b0;
            mc_rd_enable <= 1'b0;
            err          <= 1'b1;
            state        <= S_ERR;
          end
        end
        S_RD_REL: begin
          if (!mc_rd_done) begin
            iter_idx <= iter_idx + ITER_W'(1);
            addr_q   <= addr_q + stride_q;
            val_q    <= val_q + 32'd1;
            state    <= S_NEXT;
          end else if (tmo_hit) begin
            mc_wr_enable <= 1'b0;
            mc_rd_enable <= 1'b0;
            err          <= 1'b1;
            state        <= S_ERR;
          end
        end
        default: begin
          mc_wr_enable <= 1'b0;
          mc_rd_enable <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  // Run statistics: cleared by an accepted start, updated on the cycle each done is first seen.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      wr_cycles_total <= '0;
      rd_cycles_total <= '0;
      rd_lat_min      <= 32'hFFFF_FFFF;
      rd_lat_max      <= 32'd0;
      mismatch_cnt    <= '0;
    end else begin
      if (wr_fire) begin
        wr_cycles_total <= sat_add(wr_cycles_total, mc_wr_clk_count);
      end
      if (rd_fire) begin
        rd_cycles_total <= sat_add(rd_cycles_total, mc_rd_clk_count);
        if (mc_rd_clk_count < rd_lat_min) begin
          rd_lat_min <= mc_rd_clk_count;
        end
        if (mc_rd_clk_count > rd_lat_max) begin
          rd_lat_max <= mc_rd_clk_count;
        end
        // Written lines hold 16 identical words per beat, so a clean read hashes to zero.
        if (mode_q[1] && (mc_rhash != 32'd0) && (mismatch_cnt != {ITER_W{1'b1}})) begin
          mismatch_cnt <= mismatch_cnt + ITER_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_perf_seq.sv
module tb_dram_perf_seq;

  localparam int ITER_W = 16;
  localparam int ACC_W  = 40;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        cfg_mode;
  logic [31:0]       cfg_start_addr;
  logic [31:0]       cfg_addr_stride;
  logic [31:0]       cfg_burst_len;
  logic [31:0]       cfg_seed;
  logic [ITER_W-1:0] cfg_iters;
  logic [31:0]       cfg_timeout;
  logic              mc_wr_enable;
  logic              mc_rd_enable;
  logic [31:0]       mc_start_addr;
  logic [31:0]       mc_burst_len;
  logic [31:0]       mc_write_val;
  logic              mc_wr_done;
  logic              mc_rd_done;
  logic [31:0]       mc_rhash;
  logic [31:0]       mc_rd_clk_count;
  logic [31:0]       mc_wr_clk_count;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_idx;
  logic [ACC_W-1:0]  rd_cycles_total;
  logic [ACC_W-1:0]  wr_cycles_total;
  logic [31:0]       rd_lat_min;
  logic [31:0]       rd_lat_max;
  logic [ITER_W-1:0] mismatch_cnt;

  dram_perf_seq #(.ITER_W(ITER_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_mode(cfg_mode), .cfg_start_addr(cfg_start_addr), .cfg_addr_stride(cfg_addr_stride),
    .cfg_burst_len(cfg_burst_len), .cfg_seed(cfg_seed), .cfg_iters(cfg_iters), .cfg_timeout(cfg_timeout),
    .mc_wr_enable(mc_wr_enable), .mc_rd_enable(mc_rd_enable), .mc_start_addr(mc_start_addr),
    .mc_burst_len(mc_burst_len), .mc_write_val(mc_write_val),
    .mc_wr_done(mc_wr_done), .mc_rd_done(mc_rd_done), .mc_rhash(mc_rhash),
    .mc_rd_clk_count(mc_rd_clk_count), .mc_wr_clk_count(mc_wr_clk_count),
    .busy(busy), .done(done), .err(err), .iter_idx(iter_idx),
    .rd_cycles_total(rd_cycles_total), .wr_cycles_total(wr_cycles_total),
    .rd_lat_min(rd_lat_min), .rd_lat_max(rd_lat_max), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Per-pass engine responses, indexed by pass number.
  logic [31:0] wr_cnt_tab [512];
  logic [31:0] rd_cnt_tab [512];
  logic [31:0] rhash_tab  [512];

  int          eng_lat  = 1;
  bit          stall_wr = 1'b0;
  int          wr_served, rd_served, wr_en_cycles, rd_en_cycles;
  bit          arg_changed, in_ph;
  logic [95:0] cap_args;
  logic [95:0] wr_log [$];
  logic [95:0] rd_log [$];
  int          wr_cnt, rd_cnt;

  logic [1:0]  cur_mode;
  int          cur_iters;
  logic [31:0] cur_addr, cur_stride, cur_burst, cur_seed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Engine model: raises done eng_lat cycles after its enable, holds it until the enable drops.
  initial begin
    mc_wr_done = 1'b0; mc_rd_done = 1'b0; mc_rhash = 32'd0;
    mc_rd_clk_count = 32'd0; mc_wr_clk_count = 32'd0;
    wr_cnt = 0; rd_cnt = 0; in_ph = 1'b0;
    forever begin
      @(negedge clk);
      if (mc_wr_enable === 1'b1) wr_en_cycles++;
      if (mc_rd_enable === 1'b1) rd_en_cycles++;
      if (mc_wr_enable === 1'b1 || mc_rd_enable === 1'b1) begin
        if (!in_ph) begin
          in_ph = 1'b1;
          cap_args = {mc_start_addr, mc_write_val, mc_burst_len};
        end else if (cap_args !== {mc_start_addr, mc_write_val, mc_burst_len}) begin
          arg_changed = 1'b1;
        end
      end else begin
        in_ph = 1'b0;
      end
      if (mc_wr_enable !== 1'b1) begin
        wr_cnt = 0; mc_wr_done = 1'b0;
      end else if (!mc_wr_done) begin
        wr_cnt++;
        if (!stall_wr && wr_cnt >= eng_lat) begin
          mc_wr_clk_count = wr_cnt_tab[wr_served % 512];
          wr_log.push_back({mc_start_addr, mc_write_val, mc_burst_len});
          wr_served++;
          mc_wr_done = 1'b1;
        end
      end
      if (mc_rd_enable !== 1'b1) begin
        rd_cnt = 0; mc_rd_done = 1'b0;
      end else if (!mc_rd_done) begin
        rd_cnt++;
        if (rd_cnt >= eng_lat) begin
          mc_rd_clk_count = rd_cnt_tab[rd_served % 512];
          mc_rhash        = rhash_tab[rd_served % 512];
          rd_log.push_back({mc_start_addr, mc_write_val, mc_burst_len});
          rd_served++;
          mc_rd_done = 1'b1;
        end
      end
    end
  end

  task automatic fill_random(input bit with_bad_hash);
    for (int i = 0; i < 512; i++) begin
      wr_cnt_tab[i] = $urandom_range(1, 5000);
      rd_cnt_tab[i] = $urandom_range(1, 5000);
      rhash_tab[i]  = (with_bad_hash && $urandom_range(0, 1) == 1) ? ($urandom | 32'd1) : 32'd0;
    end
  endtask

  // Called at a negedge: pulses start and checks the first two cycles of the run.
  task automatic launch(input logic [1:0] m, input int it, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] b, input logic [31:0] sd, input logic [31:0] to);
    cur_mode = m; cur_iters = it; cur_addr = a; cur_stride = s; cur_burst = b; cur_seed = sd;
    cfg_mode = m; cfg_iters = ITER_W'(it); cfg_start_addr = a; cfg_addr_stride = s;
    cfg_burst_len = b; cfg_seed = sd; cfg_timeout = to;
    wr_served = 0; rd_served = 0; wr_en_cycles = 0; rd_en_cycles = 0; arg_changed = 1'b0;
    wr_log.delete(); rd_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_en_low", 64'({mc_wr_enable, mc_rd_enable}), 64'd0);
    @(negedge clk);
    if (it == 0)        check("zero_iter_done_at_2", 64'({done, busy, mc_wr_enable, mc_rd_enable}), 64'b1000);
    else if (m == 2'd1) check("rd_en_at_2", 64'({mc_wr_enable, mc_rd_enable}), 64'b01);
    else                check("wr_en_at_2", 64'({mc_wr_enable, mc_rd_enable}), 64'b10);
  endtask

  task automatic wait_end(input int bound);
    int c = 0;
    while (!(done === 1'b1 || err === 1'b1) && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("run_terminates", 64'(done === 1'b1 || err === 1'b1), 64'd1);
  endtask

  // Reference outcome of a completed run, derived from the pass rules and the engine tables.
  task automatic verify_run(input string tag);
    logic [63:0] ewr, erd, emin, emax;
    logic [31:0] ea, ev;
    int emis, nw, nr;
    ewr = 0; erd = 0; emin = 64'hFFFF_FFFF; emax = 0; emis = 0;
    nw = (cur_mode != 2'd1) ? cur_iters : 0;
    nr = (cur_mode != 2'd0) ? cur_iters : 0;
    for (int i = 0; i < cur_iters; i++) begin
      if (cur_mode != 2'd1) begin
        ewr = ewr + 64'(wr_cnt_tab[i]);
        if (ewr > ACC_MAX) ewr = ACC_MAX;
      end
      if (cur_mode != 2'd0) begin
        erd = erd + 64'(rd_cnt_tab[i]);
        if (erd > ACC_MAX) erd = ACC_MAX;
        if (64'(rd_cnt_tab[i]) < emin) emin = 64'(rd_cnt_tab[i]);
        if (64'(rd_cnt_tab[i]) > emax) emax = 64'(rd_cnt_tab[i]);
        if (cur_mode[1] && rhash_tab[i] != 32'd0 && emis < 65535) emis++;
      end
    end
    check({tag, "_flags"}, 64'({done, err, busy, mc_wr_enable, mc_rd_enable}), 64'b10000);
    check({tag, "_iter_idx"}, 64'(iter_idx), 64'(cur_iters));
    check({tag, "_wr_total"}, 64'(wr_cycles_total), ewr);
    check({tag, "_rd_total"}, 64'(rd_cycles_total), erd);
    check({tag, "_lat_min"}, 64'(rd_lat_min), emin);
    check({tag, "_lat_max"}, 64'(rd_lat_max), emax);
    check({tag, "_mismatch"}, 64'(mismatch_cnt), 64'(emis));
    check({tag, "_n_wr"}, 64'(wr_log.size()), 64'(nw));
    check({tag, "_n_rd"}, 64'(rd_log.size()), 64'(nr));
    check({tag, "_args_stable"}, 64'(arg_changed), 64'd0);
    for (int i = 0; i < wr_log.size() && i < nw; i++) begin
      ea = cur_addr + cur_stride * 32'(i);
      ev = cur_seed + 32'(i);
      check({tag, "_wr_addr_val"}, wr_log[i][95:32], {ea, ev});
      check({tag, "_wr_burst"}, 64'(wr_log[i][31:0]), 64'(cur_burst));
    end
    for (int i = 0; i < rd_log.size() && i < nr; i++) begin
      ea = cur_addr + cur_stride * 32'(i);
      ev = cur_seed + 32'(i);
      check({tag, "_rd_addr_val"}, rd_log[i][95:32], {ea, ev});
      check({tag, "_rd_burst"}, 64'(rd_log[i][31:0]), 64'(cur_burst));
    end
  endtask

  initial begin
    logic [ITER_W-1:0] s_iter;
    logic [31:0]       s_addr, s_val;
    logic [ACC_W-1:0]  s_wr;
    int                c;

    rst = 1'b1; start = 1'b0;
    cfg_mode = 2'd0; cfg_start_addr = 32'd0; cfg_addr_stride = 32'd0; cfg_burst_len = 32'd0;
    cfg_seed = 32'd0; cfg_iters = '0; cfg_timeout = 32'd0;
    for (int i = 0; i < 512; i++) begin
      wr_cnt_tab[i] = 32'd0; rd_cnt_tab[i] = 32'd0; rhash_tab[i] = 32'd0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_flags", 64'({busy, done, err, mc_wr_enable, mc_rd_enable}), 64'd0);
    check("rst_args", {mc_start_addr, mc_write_val}, 64'd0);
    check("rst_burst", 64'(mc_burst_len), 64'd0);
    check("rst_totals", 64'(wr_cycles_total) | 64'(rd_cycles_total), 64'd0);
    check("rst_lat_min", 64'(rd_lat_min), 64'hFFFF_FFFF);
    check("rst_lat_max", 64'(rd_lat_max), 64'd0);
    check("rst_idx_mis", 64'({iter_idx, mismatch_cnt}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 2, three clean passes
    fill_random(1'b0); eng_lat = 2;
    launch(2'd2, 3, 32'h100, 32'h40, 32'd7, 32'hA5A5_0000, 32'd0);
    wait_end(2000);
    verify_run("m2_clean");
    check("m2_pass2_addr", 64'(wr_log[2][95:64]), 64'h180);
    check("m2_pass2_val", 64'(rd_log[2][63:32]), 64'hA5A5_0002);

    // Mode 2, bad hash on pass 1 only
    rhash_tab[1] = 32'h1; eng_lat = 3;
    launch(2'd2, 3, 32'h100, 32'h40, 32'd7, 32'hA5A5_0000, 32'd0);
    wait_end(2000);
    verify_run("m2_badhash");
    check("m2_badhash_cnt", 64'(mismatch_cnt), 64'd1);
    rhash_tab[1] = 32'h0;

    // Mode 1, two read passes
    rd_cnt_tab[0] = 32'd50; rd_cnt_tab[1] = 32'd80; rhash_tab[0] = 32'h77;
    launch(2'd1, 2, 32'h10, 32'h1, 32'd0, 32'd9, 32'd0);
    wait_end(2000);
    verify_run("m1");
    check("m1_min", 64'(rd_lat_min), 64'd50);
    check("m1_max", 64'(rd_lat_max), 64'd80);
    check("m1_total", 64'(rd_cycles_total), 64'd130);
    check("m1_no_wr_en", 64'(wr_en_cycles), 64'd0);
    rhash_tab[0] = 32'h0;

    // Write phase that never completes, timeout 20
    stall_wr = 1'b1;
    launch(2'd0, 2, 32'h0, 32'h1, 32'd1, 32'd0, 32'd20);
    wait_end(500);
    check("tmo_flags", 64'({done, err, busy, mc_wr_enable, mc_rd_enable}), 64'b01000);
    check("tmo_en_cycles", 64'(wr_en_cycles), 64'd20);
    check("tmo_iter_idx", 64'(iter_idx), 64'd0);
    stall_wr = 1'b0;
    @(negedge clk);

    // Zero passes
    launch(2'd2, 0, 32'h55, 32'h1, 32'd3, 32'd1, 32'd0);
    wait_end(100);
    verify_run("zero");
    check("zero_no_en", 64'(wr_en_cycles + rd_en_cycles), 64'd0);

    // start while busy is ignored
    fill_random(1'b1); eng_lat = 12;
    launch(2'd2, 3, 32'h2000, 32'h10, 32'd3, 32'h1234_5678, 32'd0);
    repeat (3) @(negedge clk);
    s_iter = iter_idx; s_addr = mc_start_addr; s_val = mc_write_val; s_wr = wr_cycles_total;
    cfg_mode = 2'd0; cfg_iters = 16'd9; cfg_start_addr = 32'hDEAD_0000; cfg_seed = 32'hBEEF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_iter", 64'(iter_idx), 64'(s_iter));
    check("busy_start_args", {mc_start_addr, mc_write_val}, {s_addr, s_val});
    check("busy_start_wr_total", 64'(wr_cycles_total), 64'(s_wr));
    check("busy_start_flags", 64'({busy, done, err, mc_wr_enable}), 64'b1001);
    wait_end(3000);
    verify_run("busy_start");

    // Reset in the middle of a read phase
    eng_lat = 5;
    launch(2'd2, 5, 32'h300, 32'h8, 32'd1, 32'd100, 32'd0);
    c = 0;
    while (mc_rd_enable !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("midrst_reached_rd", 64'(mc_rd_enable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", 64'({busy, done, err, mc_wr_enable, mc_rd_enable}), 64'd0);
    check("midrst_idx", 64'(iter_idx), 64'd0);
    check("midrst_lat_min", 64'(rd_lat_min), 64'hFFFF_FFFF);
    check("midrst_wr_total", 64'(wr_cycles_total), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Randomised runs, modes 0..3
    for (int r = 0; r < 5; r++) begin
      fill_random(1'b1);
      eng_lat = $urandom_range(1, 6);
      launch(2'($urandom_range(0, 3)), $urandom_range(1, 6), $urandom, $urandom, $urandom,
             $urandom, ($urandom_range(0, 1) == 1) ? 32'd200 : 32'd0);
      wait_end(3000);
      verify_run("rand");
    end

    // Write-count saturation over 258 passes of 0xFFFF_FFFF
    for (int i = 0; i < 512; i++) wr_cnt_tab[i] = 32'hFFFF_FFFF;
    eng_lat = 1;
    launch(2'd0, 258, 32'h0, 32'h1, 32'd0, 32'd0, 32'd0);
    wait_end(20000);
    verify_run("sat");
    check("sat_wr_total", 64'(wr_cycles_total), ACC_MAX);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
